pq_sorted_ovf: RTL and testbench
================================

// Module: pq_sorted_ovf
// PURPOSE
// - Parametrised successor to the single-mode hardware priority queue.
// - Stores DEPTH (key, id) entries sorted ascending by key in a shift-register array.
// - Exposes the head (smallest key) combinationally and serves push, pop and drop-by-ID.
// - Adds same-cycle push+pop, FIFO ordering among equal keys, and a configurable full policy (reject or evict-largest).
// - Sits between task producers and a scheduler as the ready-queue primitive.
// PARAMETERS
// - DEPTH     8   number of entries (>=2)
// - DW        8   key/data width; smaller value = higher priority
// - IW        4   ID width; must satisfy 2**IW >= 2*DEPTH
// - OVF_MODE  0   0: push rejected when full; 1: push accepted when full, largest entry evicted
// - CW        $clog2(DEPTH+1)   occupancy counter width (derived, not overridden)
// PORTS
// - clk_i        in   1    clock
// - rst_i        in   1    synchronous reset, active-high
// - push_i       in   1    push request
// - push_data_i  in   DW   key to insert
// - push_rdy_o   out  1    push accepted this cycle when push_i & push_rdy_o
// - push_id_o    out  IW   ID that the current push receives (comb.)
// - pop_i        in   1    pop request
// - pop_rdy_o    out  1    = ~empty_o
// - pop_data_o   out  DW   head key (comb.); valid when ~empty_o
// - pop_id_o     out  IW   head ID (comb.)
// - drop_i       in   1    drop-by-ID request
// - drop_id_i    in   IW   ID to remove
// - drop_rdy_o   out  1    drop accepted this cycle when drop_i & drop_rdy_o
// - drop_hit_o   out  1    registered 1-cycle pulse: last accepted drop removed an entry
// - full_o       out  1    cnt_o == DEPTH
// - empty_o      out  1    cnt_o == 0
// - cnt_o        out  CW   occupancy
// - ovf_o        out  1    registered 1-cycle pulse: an entry was evicted (OVF_MODE=1 only)
// - ovf_data_o   out  DW   evicted key, held until the next eviction
// - ovf_id_o     out  IW   evicted ID, held until the next eviction
// BEHAVIOUR
// - Reset (rst_i high at a clock edge): all entries invalid; cnt_o=0, empty_o=1, full_o=0.
//   - drop_hit_o=0, ovf_o=0, ovf_data_o=0, ovf_id_o=0, ID counter=0; pop_data_o/pop_id_o read 0.
//   - Reset mid-operation discards all content; no handshake completes in that cycle.
// - All handshakes complete at the rising edge; the result is visible on pop_*, cnt_o and the flags in the next cycle.
// - push_rdy_o = ~full_o | pop_i | (OVF_MODE==1).
// - drop_rdy_o = ~push_i & ~pop_i. A drop is exclusive and loses to push/pop.
// - Push inserts after the last entry whose key <= push_data_i, so equal keys stay in FIFO order.
// - push_id_o = ID counter. The counter increments (mod 2**IW) only on an accepted push.
// - Pop removes the head and shifts the array up. Pop when empty is ignored, since pop_rdy_o=0.
// - Push+pop in the same cycle:
//   - The head is removed and the new key is inserted; cnt_o is unchanged.
//   - Allowed when full; never causes an eviction.
//   - When empty, only the push takes effect and cnt_o becomes 1.
// - Push when full, OVF_MODE=1, no pop:
//   - New key < tail key: tail evicted to ovf_*, new key inserted.
//   - New key >= tail key: the new entry itself goes to ovf_*; array unchanged.
//   - In both cases ovf_o pulses and cnt_o stays DEPTH.
// - Drop:
//   - Removes the head-most entry whose ID == drop_id_i, then compacts; cnt_o decrements.
//   - No match: no-op, drop_hit_o=0.
// - Width rules: keys compared unsigned; cnt_o saturates by construction, never > DEPTH.
// CONFIGURATION
// - PQ_DROP_EN defined: drop-by-ID logic, ID comparators and drop_hit_o are present as above.
// - PQ_DROP_EN undefined:
//   - Drop logic is removed; drop_i and drop_id_i are ignored.
//   - drop_rdy_o=0 and drop_hit_o=0 constant.
//   - push_id_o and pop_id_o are still generated.
// TESTING
// - Reset, push F0,15,87, pop x3 -> pops 15,87,F0 with IDs 1,2,0; cnt_o 3->0; empty_o=1.
// - Push 01(id0), 11(id1), 11(id2), pop x3 -> 01, then 11/id1 before 11/id2 (FIFO tie order).
// - Push 01,EB,AF, pop, drop_id=2 -> drop_hit_o=1, AF removed, head=EB, cnt_o=1.
//   - Then drop_id=7 -> drop_hit_o=0, cnt_o unchanged.
// - Fill DEPTH=8 with 10..80, push 05 with pop_i=1 -> 10 popped, 05 inserted, cnt_o=8, ovf_o=0.
// - OVF_MODE=1, full 10..80:
//   - push 35 -> ovf_o=1, ovf_data_o=80, cnt_o=8.
//   - push 90 -> ovf_data_o=90, array unchanged.
// - OVF_MODE=0, full:
//   - push_rdy_o=0 and the push is stalled until a pop.
//   - Assert rst_i mid-sequence -> next cycle empty_o=1, cnt_o=0, push_id_o=0.

Source files
------------

// File: rtl/pq_sorted_ovf_if.sv
// Handshake bundle for pq_sorted_ovf: push, pop and drop channels plus status and overflow outputs.
interface pq_sorted_ovf_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = 8,
    parameter int unsigned IW    = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          push_i;
    logic [DW-1:0] push_data_i;
    logic          push_rdy_o;
    logic [IW-1:0] push_id_o;
    logic          pop_i;
    logic          pop_rdy_o;
    logic [DW-1:0] pop_data_o;
    logic [IW-1:0] pop_id_o;
    logic          drop_i;
    logic [IW-1:0] drop_id_i;
    logic          drop_rdy_o;
    logic          drop_hit_o;
    logic          full_o;
    logic          empty_o;
    logic [CW-1:0] cnt_o;
    logic          ovf_o;
    logic [DW-1:0] ovf_data_o;
    logic [IW-1:0] ovf_id_o;

    modport master (
        output push_i, push_data_i, pop_i, drop_i, drop_id_i,
        input  push_rdy_o, push_id_o, pop_rdy_o, pop_data_o, pop_id_o,
               drop_rdy_o, drop_hit_o, full_o, empty_o, cnt_o,
               ovf_o, ovf_data_o, ovf_id_o
    );

    modport slave (
        input  push_i, push_data_i, pop_i, drop_i, drop_id_i,
        output push_rdy_o, push_id_o, pop_rdy_o, pop_data_o, pop_id_o,
               drop_rdy_o, drop_hit_o, full_o, empty_o, cnt_o,
               ovf_o, ovf_data_o, ovf_id_o
    );
endinterface

// File: rtl/pq_sorted_ovf.sv
// Sorted shift-array priority queue with push+pop, FIFO tie order and reject/evict full policy.
// Drop-by-ID logic is present only when PQ_DROP_EN is defined.
module pq_sorted_ovf #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned DW       = 8,
    parameter int unsigned IW       = 4,
    parameter int unsigned OVF_MODE = 0
) (
    input logic           clk_i,
    input logic           rst_i,
    pq_sorted_ovf_if.slave bus
);
    localparam int unsigned   CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DW-1:0] key_q [DEPTH];
    logic [IW-1:0] id_q  [DEPTH];
    logic [CW-1:0] cnt_q;
    logic [IW-1:0] id_ctr_q;
    logic          ovf_q;
    logic [DW-1:0] ovf_data_q;
    logic [IW-1:0] ovf_id_q;
    logic          drop_hit_q;

    logic          full, empty, push_rdy, push_acc, pop_acc;
    logic [DW-1:0] key_a [DEPTH];
    logic [IW-1:0] id_a  [DEPTH];
    logic [DW-1:0] key_n [DEPTH];
    logic [IW-1:0] id_n  [DEPTH];
    logic [CW-1:0] cnt_a, cnt_n, pos;
    logic          evict, self_evict;
    logic [DW-1:0] ovf_data_n;
    logic [IW-1:0] ovf_id_n;

    assign full     = (cnt_q == DEPTH_C);
    assign empty    = (cnt_q == '0);
    assign push_rdy = ~full | bus.pop_i | (OVF_MODE != 0);
    assign push_acc = bus.push_i & push_rdy;
    assign pop_acc  = bus.pop_i & ~empty;

    // Pop is applied first, then the insert runs on the compacted array, so push+pop never evicts.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
            key_a[i] = pop_acc ? key_q[i+1] : key_q[i];
            id_a[i]  = pop_acc ? id_q[i+1]  : id_q[i];
        end
        key_a[DEPTH-1] = pop_acc ? '0 : key_q[DEPTH-1];
        id_a[DEPTH-1]  = pop_acc ? '0 : id_q[DEPTH-1];
        cnt_a = cnt_q - CW'(pop_acc);

        pos = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i) < cnt_a && key_a[i] <= bus.push_data_i)
                pos = pos + CW'(1);
        end

        evict      = push_acc && (cnt_a == DEPTH_C);
        self_evict = evict && (pos == DEPTH_C);

        key_n = key_a;
        id_n  = id_a;
        if (push_acc && !self_evict) begin
            if (pos == '0) begin
                key_n[0] = bus.push_data_i;
                id_n[0]  = id_ctr_q;
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (CW'(i) == pos) begin
                    key_n[i] = bus.push_data_i;
                    id_n[i]  = id_ctr_q;
                end else if (CW'(i) > pos) begin
                    key_n[i] = key_a[i-1];
                    id_n[i]  = id_a[i-1];
                end
            end
        end

        cnt_n      = evict ? cnt_a : cnt_a + CW'(push_acc);
        ovf_data_n = self_evict ? bus.push_data_i : key_a[DEPTH-1];
        ovf_id_n   = self_evict ? id_ctr_q : id_a[DEPTH-1];
    end

`ifdef PQ_DROP_EN
    logic          drop_acc, hit;
    logic [CW-1:0] hit_idx;
    logic [DW-1:0] key_d [DEPTH];
    logic [IW-1:0] id_d  [DEPTH];

    assign drop_acc = bus.drop_i & ~bus.push_i & ~bus.pop_i;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!hit && CW'(i) < cnt_q && id_q[i] == bus.drop_id_i) begin
                hit     = 1'b1;
                hit_idx = CW'(i);
            end
        end
        key_d = key_q;
        id_d  = id_q;
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
            if (hit && CW'(i) >= hit_idx) begin
                key_d[i] = key_q[i+1];
                id_d[i]  = id_q[i+1];
            end
        end
        if (hit) begin
            key_d[DEPTH-1] = '0;
            id_d[DEPTH-1]  = '0;
        end
    end

    assign bus.drop_rdy_o = ~bus.push_i & ~bus.pop_i;
`else
    logic unused_drop;
    assign unused_drop    = ^{bus.drop_i, bus.drop_id_i};
    assign bus.drop_rdy_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            key_q      <= '{default: '0};
            id_q       <= '{default: '0};
            cnt_q      <= '0;
            id_ctr_q   <= '0;
            ovf_q      <= 1'b0;
            ovf_data_q <= '0;
            ovf_id_q   <= '0;
            drop_hit_q <= 1'b0;
        end else begin
            ovf_q      <= evict;
            drop_hit_q <= 1'b0;
            if (evict) begin
                ovf_data_q <= ovf_data_n;
                ovf_id_q   <= ovf_id_n;
            end
            if (push_acc)
                id_ctr_q <= id_ctr_q + IW'(1);
`ifdef PQ_DROP_EN
            if (drop_acc) begin
                key_q      <= key_d;
                id_q       <= id_d;
                cnt_q      <= cnt_q - CW'(hit);
                drop_hit_q <= hit;
            end else begin
                key_q <= key_n;
                id_q  <= id_n;
                cnt_q <= cnt_n;
            end
`else
            key_q <= key_n;
            id_q  <= id_n;
            cnt_q <= cnt_n;
`endif
        end
    end

    assign bus.push_rdy_o = push_rdy;
    assign bus.push_id_o  = id_ctr_q;
    assign bus.pop_rdy_o  = ~empty;
    assign bus.pop_data_o = key_q[0];
    assign bus.pop_id_o   = id_q[0];
    assign bus.drop_hit_o = drop_hit_q;
    assign bus.full_o     = full;
    assign bus.empty_o    = empty;
    assign bus.cnt_o      = cnt_q;
    assign bus.ovf_o      = ovf_q;
    assign bus.ovf_data_o = ovf_data_q;
    assign bus.ovf_id_o   = ovf_id_q;
endmodule

// File: tb/tb_pq_sorted_ovf.sv
// Directed bench for pq_sorted_ovf: a reject-mode and an evict-mode instance share one stimulus stream.
module tb_pq_sorted_ovf;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0, pop = 1'b0, drop = 1'b0;
    logic [7:0] push_data = '0;
    logic [3:0] drop_id = '0;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    pq_sorted_ovf_if #(.DEPTH(8), .DW(8), .IW(4)) bus0 ();
    pq_sorted_ovf_if #(.DEPTH(8), .DW(8), .IW(4)) bus1 ();

    assign bus0.push_i = push;  assign bus0.push_data_i = push_data;
    assign bus0.pop_i  = pop;   assign bus0.drop_i = drop;  assign bus0.drop_id_i = drop_id;
    assign bus1.push_i = push;  assign bus1.push_data_i = push_data;
    assign bus1.pop_i  = pop;   assign bus1.drop_i = drop;  assign bus1.drop_id_i = drop_id;

    pq_sorted_ovf #(.DEPTH(8), .DW(8), .IW(4), .OVF_MODE(0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
    pq_sorted_ovf #(.DEPTH(8), .DW(8), .IW(4), .OVF_MODE(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        push = 0; pop = 0; drop = 0;
        rst = 1; step(); rst = 0;
    endtask

    task automatic push_one(input logic [7:0] k);
        push = 1; push_data = k; step(); push = 0;
    endtask

    task automatic pop_one();
        pop = 1; step(); pop = 0;
    endtask

    task automatic fill();
        for (int i = 0; i < 8; i++) push_one(8'((i + 1) * 16));
    endtask

    task automatic test_reset();
        push = 1; push_data = 8'h42; rst = 1; step(); rst = 0; push = 0; #1;
        n_cmp++; if (bus0.cnt_o !== 4'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", bus0.cnt_o); end
        n_cmp++; if (bus0.empty_o !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", bus0.empty_o); end
        n_cmp++; if (bus0.full_o !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", bus0.full_o); end
        n_cmp++; if (bus0.pop_data_o !== 8'h00 || bus0.pop_id_o !== 4'h0) begin n_err++; $display("FAIL reset_head got %h/%h want 00/0", bus0.pop_data_o, bus0.pop_id_o); end
        n_cmp++; if (bus0.push_id_o !== 4'h0) begin n_err++; $display("FAIL reset_push_id got %h want 0", bus0.push_id_o); end
        n_cmp++; if (bus1.ovf_o !== 1'b0 || bus1.ovf_data_o !== 8'h00 || bus1.ovf_id_o !== 4'h0) begin n_err++; $display("FAIL reset_ovf got %b/%h/%h want 0/00/0", bus1.ovf_o, bus1.ovf_data_o, bus1.ovf_id_o); end
        n_cmp++; if (bus0.drop_hit_o !== 1'b0 || bus0.pop_rdy_o !== 1'b0) begin n_err++; $display("FAIL reset_flags got hit=%b pop_rdy=%b want 0/0", bus0.drop_hit_o, bus0.pop_rdy_o); end
    endtask

    task automatic test_basic_order();
        logic [7:0] pk [3];
        logic [7:0] ek [3];
        logic [3:0] ei [3];
        pk = '{8'hF0, 8'h15, 8'h87};
        ek = '{8'h15, 8'h87, 8'hF0};
        ei = '{4'd1, 4'd2, 4'd0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus0.push_id_o !== 4'(i)) begin n_err++; $display("FAIL basic_push_id[%0d] got %h want %h", i, bus0.push_id_o, 4'(i)); end
            push_one(pk[i]);
        end
        n_cmp++; if (bus0.cnt_o !== 4'd3) begin n_err++; $display("FAIL basic_cnt got %0d want 3", bus0.cnt_o); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus0.pop_data_o !== ek[i] || bus0.pop_id_o !== ei[i]) begin n_err++; $display("FAIL basic_pop[%0d] got %h/%h want %h/%h", i, bus0.pop_data_o, bus0.pop_id_o, ek[i], ei[i]); end
            pop_one();
        end
        n_cmp++; if (bus0.cnt_o !== 4'd0 || bus0.empty_o !== 1'b1) begin n_err++; $display("FAIL basic_empty got cnt=%0d empty=%b want 0/1", bus0.cnt_o, bus0.empty_o); end
        pop_one();
        n_cmp++; if (bus0.cnt_o !== 4'd0) begin n_err++; $display("FAIL basic_pop_empty got cnt=%0d want 0", bus0.cnt_o); end
    endtask

    task automatic test_fifo_ties();
        logic [7:0] ek [3];
        logic [3:0] ei [3];
        ek = '{8'h01, 8'h11, 8'h11};
        ei = '{4'd0, 4'd1, 4'd2};
        do_reset();
        push_one(8'h01); push_one(8'h11); push_one(8'h11);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus1.pop_data_o !== ek[i] || bus1.pop_id_o !== ei[i]) begin n_err++; $display("FAIL tie_pop[%0d] got %h/%h want %h/%h", i, bus1.pop_data_o, bus1.pop_id_o, ek[i], ei[i]); end
            pop_one();
        end
    endtask

    task automatic test_drop();
        do_reset();
        push_one(8'h01); push_one(8'hEB); push_one(8'hAF);
        pop_one();
`ifdef PQ_DROP_EN
        push = 1; drop = 1; drop_id = 4'd2; #1;
        n_cmp++; if (bus0.drop_rdy_o !== 1'b0) begin n_err++; $display("FAIL drop_rdy_push got %b want 0", bus0.drop_rdy_o); end
        push = 0; #1;
        n_cmp++; if (bus0.drop_rdy_o !== 1'b1) begin n_err++; $display("FAIL drop_rdy got %b want 1", bus0.drop_rdy_o); end
        step(); drop = 0;
        n_cmp++; if (bus0.drop_hit_o !== 1'b1) begin n_err++; $display("FAIL drop_hit got %b want 1", bus0.drop_hit_o); end
        n_cmp++; if (bus0.cnt_o !== 4'd1 || bus0.pop_data_o !== 8'hEB || bus0.pop_id_o !== 4'd1) begin n_err++; $display("FAIL drop_after got cnt=%0d head=%h/%h want 1 EB/1", bus0.cnt_o, bus0.pop_data_o, bus0.pop_id_o); end
        step();
        n_cmp++; if (bus0.drop_hit_o !== 1'b0) begin n_err++; $display("FAIL drop_hit_pulse got %b want 0", bus0.drop_hit_o); end
        drop = 1; drop_id = 4'd7; step(); drop = 0;
        n_cmp++; if (bus0.drop_hit_o !== 1'b0 || bus0.cnt_o !== 4'd1) begin n_err++; $display("FAIL drop_miss got hit=%b cnt=%0d want 0/1", bus0.drop_hit_o, bus0.cnt_o); end
`else
        drop = 1; drop_id = 4'd2; #1;
        n_cmp++; if (bus0.drop_rdy_o !== 1'b0) begin n_err++; $display("FAIL nodrop_rdy got %b want 0", bus0.drop_rdy_o); end
        step(); drop = 0;
        n_cmp++; if (bus0.drop_hit_o !== 1'b0) begin n_err++; $display("FAIL nodrop_hit got %b want 0", bus0.drop_hit_o); end
        n_cmp++; if (bus0.cnt_o !== 4'd2 || bus0.pop_data_o !== 8'hAF || bus0.pop_id_o !== 4'd2) begin n_err++; $display("FAIL nodrop_after got cnt=%0d head=%h/%h want 2 AF/2", bus0.cnt_o, bus0.pop_data_o, bus0.pop_id_o); end
`endif
    endtask

    task automatic test_push_pop_full();
        do_reset();
        fill();
        n_cmp++; if (bus0.full_o !== 1'b1 || bus0.push_rdy_o !== 1'b0 || bus1.push_rdy_o !== 1'b1) begin n_err++; $display("FAIL full_rdy got full=%b rdy0=%b rdy1=%b want 1/0/1", bus0.full_o, bus0.push_rdy_o, bus1.push_rdy_o); end
        push = 1; push_data = 8'h05; pop = 1; #1;
        n_cmp++; if (bus0.push_rdy_o !== 1'b1) begin n_err++; $display("FAIL pp_rdy got %b want 1", bus0.push_rdy_o); end
        step(); push = 0; pop = 0;
        n_cmp++; if (bus0.pop_data_o !== 8'h05 || bus0.pop_id_o !== 4'd8 || bus0.cnt_o !== 4'd8) begin n_err++; $display("FAIL pp_head0 got %h/%h cnt=%0d want 05/8 cnt=8", bus0.pop_data_o, bus0.pop_id_o, bus0.cnt_o); end
        n_cmp++; if (bus1.pop_data_o !== 8'h05 || bus1.cnt_o !== 4'd8 || bus1.ovf_o !== 1'b0 || bus0.ovf_o !== 1'b0) begin n_err++; $display("FAIL pp_head1 got %h cnt=%0d ovf=%b/%b want 05 8 0/0", bus1.pop_data_o, bus1.cnt_o, bus0.ovf_o, bus1.ovf_o); end
    endtask

    task automatic test_overflow();
        logic [7:0] e1 [8];
        e1 = '{8'h10, 8'h20, 8'h30, 8'h35, 8'h40, 8'h50, 8'h60, 8'h70};
        do_reset();
        fill();
        push_one(8'h35);
        n_cmp++; if (bus1.ovf_o !== 1'b1 || bus1.ovf_data_o !== 8'h80 || bus1.ovf_id_o !== 4'd7 || bus1.cnt_o !== 4'd8) begin n_err++; $display("FAIL ovf_tail got %b %h/%h cnt=%0d want 1 80/7 cnt=8", bus1.ovf_o, bus1.ovf_data_o, bus1.ovf_id_o, bus1.cnt_o); end
        n_cmp++; if (bus0.ovf_o !== 1'b0 || bus0.cnt_o !== 4'd8 || bus0.push_id_o !== 4'd8 || bus1.push_id_o !== 4'd9) begin n_err++; $display("FAIL ovf_reject got ovf0=%b cnt0=%0d id0=%h id1=%h want 0 8 8 9", bus0.ovf_o, bus0.cnt_o, bus0.push_id_o, bus1.push_id_o); end
        push_one(8'h90);
        n_cmp++; if (bus1.ovf_o !== 1'b1 || bus1.ovf_data_o !== 8'h90 || bus1.ovf_id_o !== 4'd9) begin n_err++; $display("FAIL ovf_self got %b %h/%h want 1 90/9", bus1.ovf_o, bus1.ovf_data_o, bus1.ovf_id_o); end
        step();
        n_cmp++; if (bus1.ovf_o !== 1'b0 || bus1.ovf_data_o !== 8'h90) begin n_err++; $display("FAIL ovf_hold got %b %h want 0 90", bus1.ovf_o, bus1.ovf_data_o); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (bus1.pop_data_o !== e1[i] || bus0.pop_data_o !== 8'((i + 1) * 16)) begin n_err++; $display("FAIL ovf_drain[%0d] got %h/%h want %h/%h", i, bus1.pop_data_o, bus0.pop_data_o, e1[i], 8'((i + 1) * 16)); end
            pop_one();
        end
    endtask

    task automatic test_stall_reset();
        do_reset();
        fill();
        push = 1; push_data = 8'h35;
        step(); step();
        n_cmp++; if (bus0.cnt_o !== 4'd8 || bus0.push_id_o !== 4'd8 || bus0.push_rdy_o !== 1'b0 || bus0.pop_data_o !== 8'h10) begin n_err++; $display("FAIL stall got cnt=%0d id=%h rdy=%b head=%h want 8 8 0 10", bus0.cnt_o, bus0.push_id_o, bus0.push_rdy_o, bus0.pop_data_o); end
        pop = 1; #1;
        n_cmp++; if (bus0.push_rdy_o !== 1'b1) begin n_err++; $display("FAIL stall_release_rdy got %b want 1", bus0.push_rdy_o); end
        step(); pop = 0; push = 0;
        n_cmp++; if (bus0.pop_data_o !== 8'h20 || bus0.cnt_o !== 4'd8 || bus0.push_id_o !== 4'd9) begin n_err++; $display("FAIL stall_release got head=%h cnt=%0d id=%h want 20 8 9", bus0.pop_data_o, bus0.cnt_o, bus0.push_id_o); end
        push = 1; push_data = 8'h77; pop = 1; rst = 1;
        step(); rst = 0; push = 0; pop = 0;
        n_cmp++; if (bus0.empty_o !== 1'b1 || bus0.cnt_o !== 4'd0 || bus0.push_id_o !== 4'd0) begin n_err++; $display("FAIL midreset0 got empty=%b cnt=%0d id=%h want 1 0 0", bus0.empty_o, bus0.cnt_o, bus0.push_id_o); end
        n_cmp++; if (bus1.empty_o !== 1'b1 || bus1.cnt_o !== 4'd0 || bus1.push_id_o !== 4'd0 || bus1.ovf_o !== 1'b0) begin n_err++; $display("FAIL midreset1 got empty=%b cnt=%0d id=%h ovf=%b want 1 0 0 0", bus1.empty_o, bus1.cnt_o, bus1.push_id_o, bus1.ovf_o); end
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_fifo_ties();
        test_drop();
        test_push_pop_full();
        test_overflow();
        test_stall_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "bench timeout");
    end
endmodule
